// File: rtl/sens_acq_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sens_acq_sequencer_pkg
//  Description : Shared sensor definitions: acquisition FSM state encoding and
//                sens_mode register bit-field positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package sens_acq_sequencer_pkg;

   // sens_mode bit-field positions (shared with the register interface)
   localparam int MODE_EN_BIT   = 0;
   localparam int MODE_CONT_BIT = 1;
   localparam int MODE_K_LSB    = 2;
   localparam int MODE_K_MSB    = 3;
   localparam int MODE_P_LSB    = 4;
   localparam int MODE_P_MSB    = 7;

   // Acquisition sequencer states
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_TICK = 3'd1,
      ST_START     = 3'd2,
      ST_CONVERT   = 3'd3,
      ST_DONE      = 3'd4
   } acq_state_t;

endpackage : sens_acq_sequencer_pkg
`default_nettype wire

// File: rtl/sens_period_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sens_period_timer
//  Description : Prescaler (mod TICK_DIV) plus tick counter. Both counters are
//                held at zero while run is low, so every run starts fresh.
//                expire pulses on the (period+1)-th tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module sens_period_timer #(
   parameter int TICK_DIV = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic [3:0] period,
   output logic       expire
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0] presc;
   logic [3:0]    tick_cnt;
   logic          tick;

   assign tick   = run && (presc == PW'(TICK_DIV - 1));
   assign expire = tick && (tick_cnt == period);

   // Prescaler and tick counter, cleared whenever the timer is not running
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc    <= '0;
         tick_cnt <= '0;
      end else if (!run) begin
         presc    <= '0;
         tick_cnt <= '0;
      end else if (tick) begin
         presc    <= '0;
         tick_cnt <= tick_cnt + 4'd1;
      end else begin
         presc    <= presc + PW'(1);
      end
   end

endmodule : sens_period_timer
`default_nettype wire

// File: rtl/sens_acq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sens_acq_sequencer
//  Description : Sensor acquisition sequencer. Triggers AFE conversions,
//                averages 2^k samples per burst, publishes the result to the
//                register file and flags conversion timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module sens_acq_sequencer
   import sens_acq_sequencer_pkg::*;
#(
   parameter int TICK_DIV = 1000,
   parameter int TIMEOUT  = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] sens_mode,
   input  logic       soft_trig,
   output logic       afe_start,
   input  logic       afe_done,
   input  logic [7:0] afe_data,
   output logic [7:0] sens_data_o,
   output logic       data_valid,
   output logic       busy,
   output logic       timeout_err,
   input  logic       err_clr
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   acq_state_t state, next_state;

   // Burst configuration captured when a burst starts
   logic        cont_l;
   logic [1:0]  k_l;
   logic [3:0]  period_l;

   logic        en_q;
   logic        primed;     // en_q holds a real sample only after one clock
   logic [10:0] acc;
   logic [3:0]  samp_cnt;
   logic [TW-1:0] tmo_cnt;

   logic        enable, en_rise, expire, timed_out;
   logic [3:0]  samples_next, burst_len;

   // FSM strobes
   logic start_burst, acc_add, clr_burst, err_set, tmo_inc, out_load;

   assign enable       = sens_mode[MODE_EN_BIT];
   assign en_rise      = enable && !en_q && primed;
   assign samples_next = samp_cnt + 4'd1;
   assign burst_len    = 4'd1 << k_l;
   assign timed_out    = (tmo_cnt == TW'(TIMEOUT - 1));

   sens_period_timer #(
      .TICK_DIV (TICK_DIV)
   ) u_period_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .run    (state == ST_WAIT_TICK),
      .period (period_l),
      .expire (expire)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   // Next-state decode and per-state control strobes; disable overrides all
   always_comb begin
      next_state  = state;
      start_burst = 1'b0;
      acc_add     = 1'b0;
      clr_burst   = 1'b0;
      err_set     = 1'b0;
      tmo_inc     = 1'b0;
      out_load    = 1'b0;
      afe_start   = 1'b0;
      busy        = (state != ST_IDLE) && (state != ST_WAIT_TICK);

      if (!enable) begin
         next_state = ST_IDLE;
         clr_burst  = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (en_rise || (!sens_mode[MODE_CONT_BIT] && soft_trig)) begin
                  next_state  = ST_START;
                  start_burst = 1'b1;
               end
            end
            ST_WAIT_TICK: begin
               if (expire) begin
                  next_state  = ST_START;
                  start_burst = 1'b1;
               end
            end
            ST_START: begin
               afe_start  = 1'b1;
               next_state = ST_CONVERT;
            end
            ST_CONVERT: begin
               // a completion on the last allowed cycle still counts
               if (afe_done) begin
                  acc_add    = 1'b1;
                  next_state = (samples_next < burst_len) ? ST_START : ST_DONE;
               end else if (timed_out) begin
                  err_set    = 1'b1;
                  clr_burst  = 1'b1;
                  next_state = cont_l ? ST_WAIT_TICK : ST_IDLE;
               end else begin
                  tmo_inc    = 1'b1;
               end
            end
            ST_DONE: begin
               out_load   = 1'b1;
               next_state = cont_l ? ST_WAIT_TICK : ST_IDLE;
            end
            default: next_state = ST_IDLE;
         endcase
      end
   end

   // Datapath: config capture, accumulation, result publish, sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q        <= 1'b0;
         primed      <= 1'b0;
         cont_l      <= 1'b0;
         k_l         <= '0;
         period_l    <= '0;
         acc         <= '0;
         samp_cnt    <= '0;
         tmo_cnt     <= '0;
         sens_data_o <= 8'h00;
         data_valid  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         en_q       <= enable;
         primed     <= 1'b1;
         data_valid <= 1'b0;
         tmo_cnt    <= tmo_inc ? (tmo_cnt + TW'(1)) : '0;

         if (start_burst) begin
            cont_l   <= sens_mode[MODE_CONT_BIT];
            k_l      <= sens_mode[MODE_K_MSB:MODE_K_LSB];
            period_l <= sens_mode[MODE_P_MSB:MODE_P_LSB];
         end

         if (clr_burst) begin
            acc      <= '0;
            samp_cnt <= '0;
         end else if (acc_add) begin
            acc      <= acc + {3'b000, afe_data};
            samp_cnt <= samples_next;
         end else if (out_load) begin
            sens_data_o <= 8'(acc >> k_l);
            data_valid  <= 1'b1;
            acc         <= '0;
            samp_cnt    <= '0;
         end

         if (err_set)      timeout_err <= 1'b1;
         else if (err_clr) timeout_err <= 1'b0;
      end
   end

endmodule : sens_acq_sequencer
`default_nettype wire
